// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: Moore FSM stepping fetch/decode/execute/memory/writeback.
// Controls decode from the current state; only FETCH write enables and the BRANCH PCWrite look at inputs.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Opcode,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic [2:0]  ALUOp,
  output logic [3:0]  State,
  output logic        IllegalOp,
  output logic [15:0] InstrCount
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    IEXEC  = 4'd8,
    IWB    = 4'd9,
    BRANCH = 4'd10,
    JUMP   = 4'd11
  } state_t;

  state_t state;
  logic   retire;

  assign State = state;

  // A store retires only when its write actually lands; a reset mid-wait never counts.
  always_comb begin
    case (state)
      MEMWB, RWB, IWB, BRANCH, JUMP: retire = 1'b1;
      MEMWR:                         retire = MemReady;
      default:                       retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      IllegalOp  <= 1'b0;
      InstrCount <= 16'h0000;
    end else begin
      if (retire)
        InstrCount <= InstrCount + 16'd1;
      case (state)
        FETCH:  if (MemReady) state <= DECODE;
        DECODE: begin
          case (Opcode)
            OP_LW, OP_SW:    state <= MEMADR;
            OP_R:            state <= EXEC;
            OP_ADDI, OP_ORI: state <= IEXEC;
            OP_BEQ, OP_BNE:  state <= BRANCH;
            OP_J:            state <= JUMP;
            default: begin
              state     <= FETCH;
              IllegalOp <= 1'b1;
            end
          endcase
        end
        MEMADR: state <= (Opcode == OP_SW) ? MEMWR : MEMRD;
        MEMRD:  if (MemReady) state <= MEMWB;
        MEMWR:  if (MemReady) state <= FETCH;
        EXEC:   state <= RWB;
        IEXEC:  state <= IWB;
        default: state <= FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    MemtoReg = 1'b0;
    RegDst   = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSource = 2'b00;
    ALUOp    = 3'b000;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = 3'b100;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        ALUOp   = 3'b100;
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 3'b100;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b111;
      end
      RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = (Opcode == OP_ORI) ? 3'b101 : 3'b100;
      end
      IWB: RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 3'b001;
        PCSource = 2'b01;
        PCWrite  = ((Opcode == OP_BEQ) && Zero) || ((Opcode == OP_BNE) && !Zero);
      end
      JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
      end
      default: ;
    endcase
    // Reset gates every write/access strobe immediately, before the state register catches up.
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench: each instruction is expanded into its expected per-cycle state trace,
// and every cycle the DUT outputs are compared against a spec-level control table.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  Opcode;
  logic        Zero;
  logic        MemReady;
  logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSource;
  logic [2:0]  ALUOp;
  logic [3:0]  State;
  logic        IllegalOp;
  logic [15:0] InstrCount;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp),
    .State(State), .IllegalOp(IllegalOp), .InstrCount(InstrCount)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] m_cnt = 16'h0000;
  logic        m_ill = 1'b0;
  int          plan_st[$];
  bit          plan_mr[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
  endfunction

  function automatic int base_latency(input logic [5:0] op);
    case (op)
      6'h23:                      return 5;
      6'h2B, 6'h00, 6'h08, 6'h0D: return 4;
      6'h04, 6'h05, 6'h02:        return 3;
      default:                    return 2;
    endcase
  endfunction

  // Packed as {PCWrite,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,PCSource,ALUOp}.
  function automatic logic [15:0] exp_out(input int st, input logic [5:0] op, input logic z,
                                          input logic mr, input logic rst);
    logic pcw, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    {pcw, iord, mrd, mwr, irw, m2r, rdst, rw, asa} = 9'b0;
    asb = 2'b00; pcs = 2'b00; aop = 3'b000;
    case (st)
      0:  begin mrd = 1; asb = 2'b01; aop = 3'b100; irw = mr; pcw = mr; end
      1:  begin asb = 2'b11; aop = 3'b100; end
      2:  begin asa = 1; asb = 2'b10; aop = 3'b100; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; aop = 3'b111; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin asa = 1; asb = 2'b10; aop = (op == 6'h0D) ? 3'b101 : 3'b100; end
      9:  rw = 1;
      10: begin asa = 1; aop = 3'b001; pcs = 2'b01; pcw = (op == 6'h04 && z) || (op == 6'h05 && !z); end
      11: begin pcs = 2'b10; pcw = 1; end
      default: ;
    endcase
    if (rst) {pcw, irw, mrd, mwr, rw} = 5'b0;
    return {pcw, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, pcs, aop};
  endfunction

  function automatic logic [15:0] dut_out();
    return {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
            ALUSrcB, PCSource, ALUOp};
  endfunction

  task automatic build_plan(input logic [5:0] op, input int fw, input int mw);
    plan_st.delete(); plan_mr.delete();
    for (int i = 0; i < fw; i++) begin plan_st.push_back(0); plan_mr.push_back(1'b0); end
    plan_st.push_back(0); plan_mr.push_back(1'b1);
    plan_st.push_back(1); plan_mr.push_back(1'($urandom));
    case (op)
      6'h23, 6'h2B: begin
        plan_st.push_back(2); plan_mr.push_back(1'($urandom));
        for (int i = 0; i < mw; i++) begin
          plan_st.push_back(op == 6'h23 ? 3 : 5); plan_mr.push_back(1'b0);
        end
        plan_st.push_back(op == 6'h23 ? 3 : 5); plan_mr.push_back(1'b1);
        if (op == 6'h23) begin plan_st.push_back(4); plan_mr.push_back(1'($urandom)); end
      end
      6'h00: begin
        plan_st.push_back(6); plan_mr.push_back(1'($urandom));
        plan_st.push_back(7); plan_mr.push_back(1'($urandom));
      end
      6'h08, 6'h0D: begin
        plan_st.push_back(8); plan_mr.push_back(1'($urandom));
        plan_st.push_back(9); plan_mr.push_back(1'($urandom));
      end
      6'h04, 6'h05: begin plan_st.push_back(10); plan_mr.push_back(1'($urandom)); end
      6'h02:        begin plan_st.push_back(11); plan_mr.push_back(1'($urandom)); end
      default: ;
    endcase
  endtask

  // Inputs are applied just after a rising edge; outputs are compared on the falling edge.
  task automatic step(input int st, input logic [5:0] op, input logic z, input logic mr, input logic rst);
    reset = rst; Opcode = op; Zero = z; MemReady = mr;
    @(negedge clk);
    chk("state", 32'(State), 32'(st));
    chk("controls", 32'(dut_out()), 32'(exp_out(st, op, z, mr, rst)));
    chk("illegal", 32'(IllegalOp), 32'(m_ill));
    chk("count", 32'(InstrCount), 32'(m_cnt));
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw, input int cut);
    logic [5:0] o;
    logic       zz;
    build_plan(op, fw, mw);
    chk("latency", 32'(plan_st.size()), 32'(base_latency(op) + fw + ((op == 6'h23 || op == 6'h2B) ? mw : 0)));
    for (int i = 0; i < plan_st.size(); i++) begin
      o  = (plan_st[i] == 0) ? 6'($urandom_range(0, 63)) : op;
      zz = (plan_st[i] == 0) ? 1'($urandom) : z;
      if (i == cut) begin
        step(plan_st[i], o, zz, 1'b0, 1'b1);
        reset = 1'b0;
        m_cnt = 16'h0000; m_ill = 1'b0;
        chk("cut_state", 32'(State), 32'd0);
        chk("cut_count", 32'(InstrCount), 32'd0);
        return;
      end
      step(plan_st[i], o, zz, plan_mr[i], 1'b0);
    end
    if (is_legal(op)) m_cnt = m_cnt + 16'd1;
    else m_ill = 1'b1;
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      reset = 1'b1; Opcode = 6'($urandom); Zero = 1'($urandom); MemReady = 1'($urandom);
      @(negedge clk);
      chk("rst_strobes", 32'({PCWrite, IRWrite, MemRead, MemWrite, RegWrite}), 32'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    m_cnt = 16'h0000; m_ill = 1'b0;
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_illegal", 32'(IllegalOp), 32'd0);
    chk("rst_count", 32'(InstrCount), 32'd0);
  endtask

  logic [5:0] ops [8] = '{6'h00, 6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
  logic [5:0] rop;

  initial begin
    reset = 1'b1; Opcode = 6'h00; Zero = 1'b0; MemReady = 1'b1;
    @(posedge clk); #1;

    // Hand-computed pins on the reference table.
    chk("pin_beq_pcw", 32'(exp_out(10, 6'h04, 1'b1, 1'b0, 1'b0) & 16'h8018), 32'h8008);
    chk("pin_bne_pcw", 32'(exp_out(10, 6'h05, 1'b1, 1'b0, 1'b0) >> 15), 32'd0);
    chk("pin_ori_aluop", 32'(exp_out(8, 6'h0D, 1'b0, 1'b0, 1'b0) & 16'h0007), 32'd5);
    chk("pin_addi_aluop", 32'(exp_out(8, 6'h08, 1'b0, 1'b0, 1'b0) & 16'h0007), 32'd4);
    chk("pin_jump", 32'(exp_out(11, 6'h02, 1'b0, 1'b0, 1'b0)), 32'h8010);
    chk("pin_rwb", 32'(exp_out(7, 6'h00, 1'b0, 1'b0, 1'b0)), 32'h0300);

    reset_cycles(2);
    run_instr(6'h00, 1'b0, 0, 0, -1);
    chk("r_count_lit", 32'(InstrCount), 32'd1);

    build_plan(6'h23, 0, 3);
    chk("lw_len_lit", 32'(plan_st.size()), 32'd8);
    run_instr(6'h23, 1'b0, 0, 3, -1);
    chk("lw_count_lit", 32'(InstrCount), 32'd2);

    run_instr(6'h04, 1'b1, 0, 0, -1);
    run_instr(6'h05, 1'b1, 0, 0, -1);
    run_instr(6'h0D, 1'b0, 0, 0, -1);
    run_instr(6'h08, 1'b0, 0, 0, -1);
    run_instr(6'h02, 1'b0, 0, 0, -1);
    chk("count7_lit", 32'(InstrCount), 32'd7);
    run_instr(6'h3F, 1'b0, 0, 0, -1);
    chk("ill_lit", 32'(IllegalOp), 32'd1);
    chk("ill_count_lit", 32'(InstrCount), 32'd7);

    for (int n = 0; n < 250; n++) begin
      rop = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
      run_instr(rop, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), -1);
    end

    // Store with a long wait, cut short by reset on the third MEMWR cycle (index 5 with no fetch wait).
    run_instr(6'h2B, 1'b0, 0, 4, 5);
    run_instr(6'h00, 1'b0, 1, 0, -1);

    force dut.InstrCount = 16'hFFFF;
    #1;
    release dut.InstrCount;
    chk("preload", 32'(InstrCount), 32'hFFFF);
    m_cnt = 16'hFFFF;
    run_instr(6'h02, 1'b0, 0, 0, -1);
    chk("wrap_lit", 32'(InstrCount), 32'h0000);
    run_instr(6'h08, 1'b0, 0, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; reset input 1, synchronous active-high reset.
REQ-002 The module SHALL have Opcode input 6, instruction bits [31:26], taken from the instruction register and stable after DECODE.
REQ-003 The module SHALL have Zero input 1, ALU zero flag.
REQ-004 The module SHALL have MemReady input 1, memory handshake; the access completes in the cycle this is 1.
REQ-005 The module SHALL have these 1-bit outputs: PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite and ALUSrcA.
REQ-006 The module SHALL have these 2-bit outputs: ALUSrcB (00 regB, 01 const 4, 10 sign-extended imm, 11 imm<<2) and PCSource (00 ALU result, 01 ALUOut, 10 jump target).
REQ-007 The module SHALL have ALUOp output 3, feeding the ALU control stage: 100 add, 101 or, 111 R-type (use funct), 001 branch compare.
REQ-008 The module SHALL have State output 4, current state code, for debug.
REQ-009 The module SHALL have IllegalOp output 1, a sticky unsupported-opcode flag.
REQ-010 The module SHALL have InstrCount output 16, the number of retired instructions.

Function
REQ-011 The module SHALL implement a Moore FSM with these states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, IEXEC=8, IWB=9, BRANCH=10, JUMP=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-012 The module SHALL support these opcodes: R-type 0x00, ADDI 0x08, ORI 0x0D, LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, J 0x02.
REQ-013 In FETCH the module SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=100, PCSource=00; IRWrite=PCWrite=MemReady; it SHALL stay in FETCH while MemReady=0 and go to DECODE when MemReady=1.
REQ-014 In DECODE the module SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=100 and branch as follows: LW/SW->MEMADR, R->EXEC, ADDI/ORI->IEXEC, BEQ/BNE->BRANCH, J->JUMP, any other opcode->FETCH.
REQ-015 In MEMADR the module SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=100, then go to MEMRD for LW or MEMWR for SW.
REQ-016 In MEMRD the module SHALL drive MemRead=1 and IorD=1, hold while MemReady=0, and go to MEMWB when MemReady=1.
REQ-017 In MEMWB the module SHALL drive RegWrite=1, MemtoReg=1, RegDst=0, then go to FETCH.
REQ-018 In MEMWR the module SHALL drive MemWrite=1 and IorD=1, hold while MemReady=0, and go to FETCH when MemReady=1.
REQ-019 In EXEC the module SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=111, then go to RWB.
REQ-020 In RWB the module SHALL drive RegWrite=1, RegDst=1, MemtoReg=0, then go to FETCH.
REQ-021 In IEXEC the module SHALL drive ALUSrcA=1, ALUSrcB=10, with ALUOp=100 for ADDI or 101 for ORI, then go to IWB.
REQ-022 In IWB the module SHALL drive RegWrite=1, RegDst=0, MemtoReg=0, then go to FETCH.
REQ-023 In BRANCH the module SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01, and PCWrite=(BEQ&Zero)|(BNE&~Zero) combinationally, then go to FETCH.
REQ-024 In JUMP the module SHALL drive PCSource=10 and PCWrite=1, then go to FETCH.
REQ-025 Every output not listed for a state SHALL be 0 in that state; ALUOp SHALL be 000 where unlisted.
REQ-026 The module SHALL make no write-enable depend on MemReady except IRWrite and PCWrite in FETCH.
REQ-027 The module SHALL leave MemReady ignored in states other than FETCH, MEMRD and MEMWR.
REQ-028 IllegalOp SHALL set on the edge leaving DECODE with an unsupported opcode and clear only on reset.
REQ-029 InstrCount SHALL increment by 1 on each edge leaving MEMWB, MEMWR (with MemReady=1), RWB, IWB, BRANCH or JUMP.
REQ-030 InstrCount SHALL wrap from 0xFFFF to 0x0000.
REQ-031 InstrCount SHALL NOT increment for illegal opcodes.
REQ-032 Execution latency SHALL be, with zero-wait memory: LW 5 cycles, SW 4, R/ADDI/ORI 4, BEQ/BNE/J 3.
REQ-033 Each memory wait cycle SHALL add exactly 1 cycle.

Reset
REQ-034 When reset=1 at a rising edge, State SHALL become FETCH, IllegalOp SHALL become 0, and InstrCount SHALL become 0.
REQ-035 While reset=1, PCWrite, IRWrite, MemRead, MemWrite and RegWrite SHALL be forced to 0 combinationally.
REQ-036 Reset SHALL take precedence over every transition, including mid-wait in MEMRD/MEMWR.
REQ-037 An access cut short by reset SHALL NOT be counted.

Verification
REQ-038 The bench SHALL cover: reset held 2 cycles, then released with MemReady=1, Opcode=0x00 -> states 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7; InstrCount=1.
REQ-039 The bench SHALL cover: LW (0x23) with MemReady=0 for 3 cycles in MEMRD -> State holds at 3 for 3 cycles; MemWB after; total 8 cycles; InstrCount increments once.
REQ-040 The bench SHALL cover: BEQ with Zero=1 -> PCWrite=1 and PCSource=01 in BRANCH; BNE with Zero=1 -> PCWrite=0; both return to FETCH after 3 cycles.
REQ-041 The bench SHALL cover: ORI 0x0D -> ALUOp=101 in IEXEC; ADDI 0x08 -> ALUOp=100; J 0x02 -> PCSource=10 and PCWrite=1 in JUMP.
REQ-042 The bench SHALL cover: Opcode 0x3F -> DECODE then FETCH; IllegalOp=1 and stays 1; InstrCount unchanged.
REQ-043 The bench SHALL cover: reset asserted during a MEMWR wait -> MemWrite=0 immediately, State=0 next cycle, InstrCount=0; after preloading 0xFFFF and one more retire, InstrCount=0x0000.
